// File: rtl/iir_filter.sv
// -----------------------------------------------------------------------------
// iir_filter
//
// Purpose:
//   Direct-form-I biquad IIR filter with fixed Q2.13 coefficients.
//   The filter accepts one 10-bit signed sample per clock and produces one
//   registered 10-bit signed output per clock, with a latency of one cycle.
//
//   y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2]
//
//   The products are formed at full precision and summed without truncation.
//   The sum is rounded half-up to an integer. It is then reduced to 10 bits
//   in one of two ways, and that reduced value is fed back as y history:
//     - IIR_SATURATE_EN defined   : the value is clamped to [-512, 511].
//     - IIR_SATURATE_EN undefined : the 10 LSBs are kept (two's-complement wrap).
//
// Parameters:
//   B0, B1, B2 : feed-forward coefficients, signed 16-bit Q2.13
//   A1, A2     : feedback coefficients, signed 16-bit Q2.13
//
// Ports:
//   clk      in   1  single clock; all state updates on the rising edge
//   reset    in   1  synchronous, active-high; clears the output and all history
//   data_in  in  10  signed input sample, consumed on every rising edge
//   data_out out 10  signed filtered sample, registered
//
// Configuration macro:
//   IIR_SATURATE_EN : selects a saturating output instead of a wrapping output
// -----------------------------------------------------------------------------
module iir_filter #(
    parameter logic signed [15:0] B0 = 16'sd1536,
    parameter logic signed [15:0] B1 = 16'sd3072,
    parameter logic signed [15:0] B2 = 16'sd1536,
    parameter logic signed [15:0] A1 = -16'sd4096,
    parameter logic signed [15:0] A2 = 16'sd2048
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] data_in,
    output logic [9:0] data_out
);

    // Sign-extend the coefficients once. Every product is then a plain 32-bit
    // signed multiply. The largest magnitude is about 2^9 * 2^15 * 5, which is
    // below 2^27, so the 32-bit accumulator cannot overflow.
    localparam logic signed [31:0] B0_EXT = 32'(B0);
    localparam logic signed [31:0] B1_EXT = 32'(B1);
    localparam logic signed [31:0] B2_EXT = 32'(B2);
    localparam logic signed [31:0] A1_EXT = 32'(A1);
    localparam logic signed [31:0] A2_EXT = 32'(A2);

    logic signed [9:0]  x0;
    logic signed [9:0]  x1;
    logic signed [9:0]  x2;
    logic signed [9:0]  y1;
    logic signed [9:0]  y2;
    logic signed [31:0] acc;
    logic signed [31:0] rnd;
    logic signed [9:0]  y_next;

    assign x0 = data_in;

    // data_out is the registered y[n]. At the next edge it therefore serves
    // directly as y[n-1], so no separate y1 register is kept.
    assign y1       = data_out;

    always_comb begin
        acc = (32'(x0) * B0_EXT)
            + (32'(x1) * B1_EXT)
            + (32'(x2) * B2_EXT)
            - (32'(y1) * A1_EXT)
            - (32'(y2) * A2_EXT);
    end

    // Round half up: add 0.5 LSB in Q.13, then use an arithmetic shift so
    // that negative values floor correctly.
    assign rnd = (acc + 32'sd4096) >>> 13;

`ifdef IIR_SATURATE_EN
    always_comb begin
        if (rnd > 32'sd511) begin
            y_next = 10'sd511;
        end else if (rnd < -32'sd512) begin
            y_next = -10'sd512;
        end else begin
            y_next = rnd[9:0];
        end
    end
`else
    // In wrap mode the upper bits of rnd are discarded on purpose.
    logic rnd_unused;
    assign rnd_unused = ^rnd[31:10];

    always_comb begin
        y_next = rnd[9:0];
    end
`endif

    // Reset takes priority over the filter update. This clears all history,
    // so the first sample after reset is processed as if from a fresh start.
    always_ff @(posedge clk) begin
        if (reset) begin
            x1       <= '0;
            x2       <= '0;
            y2       <= '0;
            data_out <= '0;
        end else begin
            x1       <= x0;
            x2       <= x1;
            y2       <= y1;
            data_out <= y_next;
        end
    end

endmodule

// File: tb/tb_iir_filter.sv
// -----------------------------------------------------------------------------
// tb_iir_filter
//
// Self-checking bench for iir_filter.
//
// Two instances are checked:
//   - one with the default coefficients;
//   - one with B0 = 2.0 and all other coefficients 0, which exercises the
//     saturating / wrapping output.
//
// Each instance is compared every cycle against a difference-equation model
// written with integer arithmetic and explicit sample history. Known values
// from the filter's definition are also checked as constants.
// -----------------------------------------------------------------------------
module tb_iir_filter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] data_in = '0;
    logic [9:0] data_out;
    logic [9:0] data_in_sat = '0;
    logic [9:0] data_out_sat;

    int vectors = 0;
    int miscompares = 0;

    // Model history for the default-coefficient filter (d*) and the
    // gain-of-two filter (s*).
    int dx1 = 0, dx2 = 0, dy1 = 0, dy2 = 0;
    int sx1 = 0, sx2 = 0, sy1 = 0, sy2 = 0;

    always #5 clk = ~clk;

    iir_filter dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out)
    );

    iir_filter #(
        .B0 (16'sd16384),
        .B1 (16'sd0),
        .B2 (16'sd0),
        .A1 (16'sd0),
        .A2 (16'sd0)
    ) dut_sat (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in_sat),
        .data_out (data_out_sat)
    );

    // Reference model: evaluate the biquad equation exactly, round half up,
    // then reduce the result to a 10-bit value.
    function automatic int iirRef(input int b0, input int b1, input int b2,
                                  input int a1, input int a2,
                                  input int x0, input int x1, input int x2,
                                  input int y1, input int y2);
        longint acc;
        longint r;
        int     w;
        acc = longint'(b0) * x0 + longint'(b1) * x1 + longint'(b2) * x2
            - longint'(a1) * y1 - longint'(a2) * y2;
        r = (acc + 64'sd4096) >>> 13;
`ifdef IIR_SATURATE_EN
        if (r > 511)       w = 511;
        else if (r < -512) w = -512;
        else               w = int'(r);
`else
        w = int'(r % 1024);
        if (w >= 512)  w -= 1024;
        if (w < -512)  w += 1024;
`endif
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [9:0] observed,
                               input logic [9:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag,
                     $signed(observed), $signed(expected));
        end
    endtask

    // Drive one sample into each filter, let one rising edge pass, advance
    // the model, and compare both outputs with the model.
    task automatic applyStimulus(input logic rst, input int x, input int xs,
                                 input string tag);
        int ed;
        int es;
        @(negedge clk);
        reset       = rst;
        data_in     = 10'(x);
        data_in_sat = 10'(xs);
        @(posedge clk);
        #1;
        if (rst) begin
            dx1 = 0; dx2 = 0; dy1 = 0; dy2 = 0;
            sx1 = 0; sx2 = 0; sy1 = 0; sy2 = 0;
            ed = 0;
            es = 0;
        end else begin
            ed = iirRef(1536, 3072, 1536, -4096, 2048, x, dx1, dx2, dy1, dy2);
            es = iirRef(16384, 0, 0, 0, 0, xs, sx1, sx2, sy1, sy2);
            dx2 = dx1; dx1 = x; dy2 = dy1; dy1 = ed;
            sx2 = sx1; sx1 = xs; sy2 = sy1; sy1 = es;
        end
        checkOutput({tag, "_model"}, data_out, 10'(ed));
        checkOutput({tag, "_sat_model"}, data_out_sat, 10'(es));
    endtask

    initial begin
        int imp_exp [4];
        imp_exp = '{48, 120, 96, 18};

        $display("[TB] starting iir_filter bench");

        // Hold reset for 10 cycles with a nonzero input; the output must stay 0.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 123, 0, "reset");
            checkOutput("reset_zero", data_out, 10'd0);
        end
        // First edge after release: 123 * 0.1875 rounds to 23.
        applyStimulus(1'b0, 123, 0, "release");
        checkOutput("release_first", data_out, 10'd23);

        // Impulse response of amplitude 256.
        applyStimulus(1'b1, 0, 0, "imp_reset");
        applyStimulus(1'b0, 256, 0, "impulse");
        checkOutput("impulse_0", data_out, 10'(imp_exp[0]));
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1'b0, 0, 0, "impulse");
            checkOutput($sformatf("impulse_%0d", i), data_out, 10'(imp_exp[i]));
        end
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 0, 0, "impulse_tail");

        // Step of 400: the filter has unity DC gain, so the output settles at 400.
        applyStimulus(1'b1, 0, 0, "step_reset");
        applyStimulus(1'b0, 400, 0, "step");
        checkOutput("step_0", data_out, 10'd75);
        applyStimulus(1'b0, 400, 0, "step");
        checkOutput("step_1", data_out, 10'd263);
        for (int i = 2; i < 40; i++) applyStimulus(1'b0, 400, 0, "step");
        checkOutput("step_settled", data_out, 10'd400);

        // Reset in mid-stream discards all history.
        applyStimulus(1'b1, 400, 0, "mid_reset");
        checkOutput("mid_reset_edge", data_out, 10'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 0, 0, "post_reset");
            checkOutput("post_reset_zero", data_out, 10'd0);
        end

        // Gain-of-two filter driven out of range.
        applyStimulus(1'b0, 0, 300, "sat_pos");
`ifdef IIR_SATURATE_EN
        checkOutput("sat_pos_const", data_out_sat, 10'd511);
`else
        checkOutput("sat_pos_const", data_out_sat, 10'(-424));
`endif
        applyStimulus(1'b0, 0, -300, "sat_neg");
`ifdef IIR_SATURATE_EN
        checkOutput("sat_neg_const", data_out_sat, 10'(-512));
`else
        checkOutput("sat_neg_const", data_out_sat, 10'd424);
`endif
        applyStimulus(1'b0, 0, 255, "sat_edge_pos");
        checkOutput("sat_edge_pos_const", data_out_sat, 10'd510);
        applyStimulus(1'b0, 0, -256, "sat_edge_neg");
        checkOutput("sat_edge_neg_const", data_out_sat, 10'(-512));

        // Random samples across the full input range, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic rst;
            int   x;
            int   xs;
            rst = ($urandom_range(0, 99) < 3);
            x   = int'($urandom_range(0, 1023)) - 512;
            xs  = int'($urandom_range(0, 1023)) - 512;
            applyStimulus(rst, x, xs, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
